i8288_busctl: RTL and testbench
===============================

I8288_BUSCTL -- requirements
Module: i8288_busctl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; each rising edge is one processor T-state.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-003 SHALL have port s_n, input, 3, processor status S2..S0; 111 means passive.
REQ-004 SHALL have port aen_n, input, 1, address enable; high disables all command outputs.
REQ-005 SHALL have port cen, input, 1, command enable; low disables all command outputs and den.
REQ-006 SHALL have port ale, output, 1, address latch enable; drives the g input of the downstream address latches, which capture on its falling edge.
REQ-007 SHALL have port den, output, 1, data transceiver enable; active high.
REQ-008 SHALL have port dt_r_n, output, 1, transceiver direction; 1 means transmit (write), 0 means receive (read or INTA).
REQ-009 SHALL have ports mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n and inta_n, each an output of width 1, active-low commands.
REQ-010 SHALL have port bus_state, output, 3, current state encoding for debug: IDLE=0, T1=1, T2=2, T3=3, T4=4, HALT=5.

Function
REQ-011 SHALL decode s_n as follows: 000 is INTA, 001 is IO read, 010 is IO write, 011 is halt, 100 is code fetch (treated as memory read), 101 is memory read, 110 is memory write, 111 is passive.
REQ-012 SHALL sample s_n only in IDLE, T3 and T4, and SHALL ignore s_n in T1, T2 and HALT, except that HALT exits on passive status.
REQ-013 SHALL latch the cycle type on every transition into T1 and hold it until the next entry into T1.
REQ-014 SHALL transition from IDLE to T1 when s_n is non-passive and not halt, to HALT when s_n is 011, and otherwise remain in IDLE.
REQ-015 SHALL transition from T1 to T2 and from T2 to T3 unconditionally.
REQ-016 SHALL remain in T3, as a wait state, while s_n is non-passive, and SHALL move to T4 on the first edge at which s_n is 111.
REQ-017 SHALL transition from T4 to T1 if s_n is non-passive and not halt (back-to-back cycle), to HALT if s_n is 011, and otherwise to IDLE.
REQ-018 SHALL remain in HALT until s_n is 111, then return to IDLE, and SHALL assert no command, no ale and no den while in HALT.
REQ-019 SHALL assert ale=1 only in T1, for exactly one clk per bus cycle.
REQ-020 SHALL drive dt_r_n to its cycle-type value from T1 through T3, and SHALL hold dt_r_n=1 in T4, IDLE and HALT.
REQ-021 SHALL assert den=1 in T2 and T3 for every non-halt cycle type.
REQ-022 SHALL assert mrdc_n, iorc_n and inta_n low in T2 and T3 for the matching cycle type.
REQ-023 SHALL assert amwc_n and aiowc_n (advanced write) low in T2 and T3, and SHALL assert mwtc_n and iowc_n (normal write) low only in T3.
REQ-024 SHALL deassert all commands and den in T4, IDLE and HALT.
REQ-025 SHALL derive all outputs from registered state and latched cycle type only, with combinational gating by aen_n and cen, so that no s_n-to-output path exists.
REQ-026 SHALL force every command output to 1 whenever aen_n=1 or cen=0, and SHALL force den=0 whenever cen=0; the state machine SHALL continue to run and ale SHALL be unaffected.
REQ-027 SHALL assert at most one read-type or INTA command at any time.

Reset
REQ-028 SHALL, on a rising clk with rst_n=0, enter IDLE with ale=0, den=0, dt_r_n=1, all command outputs at 1, bus_state=0 and latched type passive.
REQ-029 SHALL apply reset asserted mid-cycle at the next edge, releasing any active command immediately, and SHALL enter no T4.
REQ-030 SHALL, on the first edge after rst_n returns to 1, sample s_n as if in IDLE.

Verification
REQ-031 Memory read: s_n=101 sampled in IDLE, then 111 in the first T3 -> ale=1 for one clk; mrdc_n=0 and den=1 for 2 clks; dt_r_n=0 for 3 clks; then IDLE.
REQ-032 IO write with 2 wait states: s_n=010 held through 3 T3 clks -> aiowc_n=0 for 4 clks, iowc_n=0 for 3 clks, dt_r_n=1 throughout.
REQ-033 Back-to-back: s_n goes to 110 at T4 of a read -> T4 is followed directly by T1, with a second ale pulse exactly 4 clks after the first.
REQ-034 Halt: s_n=011 -> bus_state=5 with no ale and all commands at 1; s_n=111 -> IDLE on the next clk.
REQ-035 Gating: aen_n=1 during an INTA cycle -> inta_n stays 1 while ale and bus_state sequence normally; cen=0 -> den stays 0.
REQ-036 Reset in T3 of a memory write -> mwtc_n=1 and bus_state=0 on the same edge, with no T4.

Source files
------------

// File: rtl/i8288_busctl_if.sv
// ----------------------------------------------------------------------------
// i8288_busctl_if
// Bus bundle between the processor status/enable pins and the 8288-style
// bus controller.
//
// Signals:
//   s_n[2:0]      processor status S2..S0, 3'b111 is passive
//   aen_n         address enable, high disables all commands
//   cen           command enable, low disables all commands and den
//   ale           address latch enable (downstream latches close on its fall)
//   den           data transceiver enable, active high
//   dt_r_n        transceiver direction, 1 = transmit, 0 = receive
//   mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n
//                 active-low command strobes
//   bus_state[2:0] debug view of the T-state
//
// Modports:
//   master  the bus controller (drives ale/den/dt_r_n/commands/bus_state)
//   slave   the processor/system side (drives status and enables)
// ----------------------------------------------------------------------------
interface i8288_busctl_if;
    logic [2:0] s_n;
    logic       aen_n;
    logic       cen;
    logic       ale;
    logic       den;
    logic       dt_r_n;
    logic       mrdc_n;
    logic       mwtc_n;
    logic       amwc_n;
    logic       iorc_n;
    logic       iowc_n;
    logic       aiowc_n;
    logic       inta_n;
    logic [2:0] bus_state;

    modport master (
        input  s_n, aen_n, cen,
        output ale, den, dt_r_n, mrdc_n, mwtc_n, amwc_n,
               iorc_n, iowc_n, aiowc_n, inta_n, bus_state
    );

    modport slave (
        output s_n, aen_n, cen,
        input  ale, den, dt_r_n, mrdc_n, mwtc_n, amwc_n,
               iorc_n, iowc_n, aiowc_n, inta_n, bus_state
    );
endinterface

// File: rtl/i8288_busctl.sv
// ----------------------------------------------------------------------------
// i8288_busctl
// Bus controller in the style of the 8288: decodes the processor status
// lines into a T1..T4 bus cycle and produces ale, den, dt_r_n and the
// active-low memory/IO/interrupt-acknowledge command strobes.
//
// Ports:
//   clk    system clock, one rising edge per processor T-state
//   rst_n  synchronous active-low reset
//   bus    i8288_busctl_if.master: status/enables in, strobes/debug out
//
// All outputs come from the registered state and the latched cycle type,
// gated only by aen_n/cen, so status changes never reach an output
// combinationally.
// ----------------------------------------------------------------------------
module i8288_busctl (
    input  logic           clk,
    input  logic           rst_n,
    i8288_busctl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [2:0] S_INTA    = 3'b000;
    localparam logic [2:0] S_IORD    = 3'b001;
    localparam logic [2:0] S_IOWR    = 3'b010;
    localparam logic [2:0] S_HALT    = 3'b011;
    localparam logic [2:0] S_CODE    = 3'b100;
    localparam logic [2:0] S_MRD     = 3'b101;
    localparam logic [2:0] S_MWR     = 3'b110;
    localparam logic [2:0] S_PASSIVE = 3'b111;

    state_t     r_state;
    state_t     w_stateNext;
    logic [2:0] r_cycleType;
    logic [2:0] w_cycleTypeNext;

    logic w_inCycle;
    logic w_cmdPhase;
    logic w_lateWrite;
    logic w_cmdEnable;
    logic w_isWrite;

    // State and latched cycle type. Reset lands in IDLE with a passive
    // type, which drops any strobe on the same edge and skips T4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cycleType <= S_PASSIVE;
        end else begin
            r_state     <= w_stateNext;
            r_cycleType <= w_cycleTypeNext;
        end
    end

    // Next-state logic. Status is only looked at in IDLE, T3 and T4, plus
    // the passive check that releases HALT. The cycle type is captured
    // only on the way into T1 and held for the whole cycle after that.
    always_comb begin
        w_stateNext     = r_state;
        w_cycleTypeNext = r_cycleType;
        case (r_state)
            ST_IDLE, ST_T4: begin
                if (bus.s_n == S_HALT) begin
                    w_stateNext = ST_HALT;
                end else if (bus.s_n != S_PASSIVE) begin
                    w_stateNext     = ST_T1;
                    w_cycleTypeNext = bus.s_n;
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            ST_T1:   w_stateNext = ST_T2;
            ST_T2:   w_stateNext = ST_T3;
            ST_T3: begin
                // Non-passive status in T3 inserts a wait state.
                if (bus.s_n == S_PASSIVE) begin
                    w_stateNext = ST_T4;
                end
            end
            ST_HALT: begin
                if (bus.s_n == S_PASSIVE) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Phase qualifiers for the output decode. Halt never enters T1, so
    // any type seen in T1..T3 is a real transfer type.
    assign w_inCycle   = (r_state == ST_T1) || (r_state == ST_T2) || (r_state == ST_T3);
    assign w_cmdPhase  = (r_state == ST_T2) || (r_state == ST_T3);
    assign w_lateWrite = (r_state == ST_T3);
    assign w_cmdEnable = !bus.aen_n && bus.cen;
    assign w_isWrite   = (r_cycleType == S_IOWR) || (r_cycleType == S_MWR);

    assign bus.ale       = (r_state == ST_T1);
    assign bus.dt_r_n    = w_inCycle ? w_isWrite : 1'b1;
    assign bus.den       = w_cmdPhase && bus.cen;
    assign bus.bus_state = r_state;

    // Read and INTA strobes are mutually exclusive because they key off a
    // single latched type. Advanced writes span T2..T3, normal writes T3.
    assign bus.mrdc_n  = !(w_cmdPhase  && w_cmdEnable &&
                           ((r_cycleType == S_CODE) || (r_cycleType == S_MRD)));
    assign bus.iorc_n  = !(w_cmdPhase  && w_cmdEnable && (r_cycleType == S_IORD));
    assign bus.inta_n  = !(w_cmdPhase  && w_cmdEnable && (r_cycleType == S_INTA));
    assign bus.amwc_n  = !(w_cmdPhase  && w_cmdEnable && (r_cycleType == S_MWR));
    assign bus.aiowc_n = !(w_cmdPhase  && w_cmdEnable && (r_cycleType == S_IOWR));
    assign bus.mwtc_n  = !(w_lateWrite && w_cmdEnable && (r_cycleType == S_MWR));
    assign bus.iowc_n  = !(w_lateWrite && w_cmdEnable && (r_cycleType == S_IOWR));

endmodule

// File: tb/tb_i8288_busctl.sv
// ----------------------------------------------------------------------------
// tb_i8288_busctl
// Self-checking bench for i8288_busctl. Bus cycles are described as
// transactions (type, wait count, gating, optional reset point) and expanded
// into a per-clock plan of expected T-states. The status driven in each clock
// is then derived from what the plan says must come next, and every clock's
// outputs are compared against the strobe rules for that phase and type.
// ----------------------------------------------------------------------------
module tb_i8288_busctl;

    localparam int PH_NONE = -1;
    localparam int PH_IDLE = 0;
    localparam int PH_T1   = 1;
    localparam int PH_T2   = 2;
    localparam int PH_T3   = 3;
    localparam int PH_T4   = 4;
    localparam int PH_HALT = 5;

    localparam int GATE_ON   = 0;
    localparam int GATE_AEN  = 1;
    localparam int GATE_CEN  = 2;
    localparam int GATE_RAND = 3;

    typedef struct {
        int         ph;
        logic [2:0] kind;
        logic       aen;
        logic       cen;
        logic       rstReq;
        logic [2:0] s;
    } entry_t;

    logic clk;
    logic rst_n;
    int   errorCount;
    int   checkCount;

    entry_t plan[$];

    i8288_busctl_if bif ();

    i8288_busctl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp, input int period);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s at clock %0d: got %0h, expected %0h",
                     tag, period, obs, exp);
        end
    endtask

    function automatic logic [2:0] randKind();
        logic [2:0] k;
        case ($urandom_range(0, 5))
            0:       k = 3'b000;
            1:       k = 3'b001;
            2:       k = 3'b010;
            3:       k = 3'b100;
            4:       k = 3'b101;
            default: k = 3'b110;
        endcase
        return k;
    endfunction

    task automatic pushPhase(input int ph, input logic [2:0] kind,
                             input int gm, input logic rstReq);
        entry_t e;
        e.ph     = ph;
        e.kind   = kind;
        e.rstReq = rstReq;
        e.s      = 3'b111;
        case (gm)
            GATE_AEN: begin e.aen = 1'b1; e.cen = 1'b1; end
            GATE_CEN: begin e.aen = 1'b0; e.cen = 1'b0; end
            GATE_RAND: begin
                e.aen = ($urandom_range(0, 5) == 0);
                e.cen = ($urandom_range(0, 5) != 0);
            end
            default: begin e.aen = 1'b0; e.cen = 1'b1; end
        endcase
        plan.push_back(e);
    endtask

    task automatic addIdle(input int n);
        for (int i = 0; i < n; i++) pushPhase(PH_IDLE, 3'b111, GATE_RAND, 1'b0);
    endtask

    task automatic addHalt(input int n);
        if (plan[$].ph == PH_HALT) addIdle(1);
        for (int i = 0; i < n; i++) pushPhase(PH_HALT, 3'b011, GATE_RAND, 1'b0);
    endtask

    // One bus cycle. rstAt selects T1/T2/first T3 (0/1/2) as the clock in
    // which reset is asserted; -1 runs the cycle to its T4.
    task automatic addCycle(input logic [2:0] kind, input int waits,
                            input int gm, input int rstAt);
        if (plan[$].ph == PH_HALT) addIdle(1);
        pushPhase(PH_T1, kind, gm, rstAt == 0);
        if (rstAt == 0) begin addIdle(1); return; end
        pushPhase(PH_T2, kind, gm, rstAt == 1);
        if (rstAt == 1) begin addIdle(1); return; end
        for (int w = 0; w <= waits; w++) begin
            pushPhase(PH_T3, kind, gm, (rstAt == 2) && (w == 0));
            if ((rstAt == 2) && (w == 0)) begin addIdle(1); return; end
        end
        pushPhase(PH_T4, kind, gm, 1'b0);
    endtask

    // Choose the status for each clock from the phase that must follow it.
    task automatic fillStatus();
        entry_t e;
        int     nextPh;
        logic [2:0] nextKind;
        for (int i = 0; i < plan.size(); i++) begin
            e        = plan[i];
            nextPh   = (i + 1 < plan.size()) ? plan[i + 1].ph : PH_IDLE;
            nextKind = (i + 1 < plan.size()) ? plan[i + 1].kind : 3'b111;
            if (e.rstReq) begin
                e.s = 3'($urandom_range(0, 7));
            end else begin
                case (e.ph)
                    PH_T1, PH_T2: e.s = 3'($urandom_range(0, 7));
                    PH_T3:   e.s = (nextPh == PH_T3) ? 3'($urandom_range(0, 6)) : 3'b111;
                    PH_HALT: e.s = (nextPh == PH_HALT) ? 3'($urandom_range(0, 6)) : 3'b111;
                    default: begin
                        if (nextPh == PH_T1)        e.s = nextKind;
                        else if (nextPh == PH_HALT) e.s = 3'b011;
                        else                        e.s = 3'b111;
                    end
                endcase
            end
            plan[i] = e;
        end
    endtask

    // Drive one clock's inputs just after the rising edge.
    task automatic applyStimulus(input entry_t e);
        bif.s_n   = e.s;
        bif.aen_n = e.aen;
        bif.cen   = e.cen;
        rst_n     = !e.rstReq;
    endtask

    // Expected outputs for one clock, from the phase and the cycle type.
    task automatic checkEntry(input entry_t e, input int period);
        logic cmdPhase, lateWrite, cmdOk, inCycle;
        logic expAle, expDen, expDtr;
        logic [6:0] expCmd, obsCmd;
        int readLows;
        cmdPhase  = (e.ph == PH_T2) || (e.ph == PH_T3);
        lateWrite = (e.ph == PH_T3);
        inCycle   = (e.ph >= PH_T1) && (e.ph <= PH_T3);
        cmdOk     = !e.aen && e.cen;
        expAle    = (e.ph == PH_T1);
        expDen    = cmdPhase && e.cen;
        expDtr    = inCycle ? ((e.kind == 3'b010) || (e.kind == 3'b110)) : 1'b1;
        expCmd[6] = !(cmdPhase && cmdOk && ((e.kind == 3'b100) || (e.kind == 3'b101)));
        expCmd[5] = !(lateWrite && cmdOk && (e.kind == 3'b110));
        expCmd[4] = !(cmdPhase && cmdOk && (e.kind == 3'b110));
        expCmd[3] = !(cmdPhase && cmdOk && (e.kind == 3'b001));
        expCmd[2] = !(lateWrite && cmdOk && (e.kind == 3'b010));
        expCmd[1] = !(cmdPhase && cmdOk && (e.kind == 3'b010));
        expCmd[0] = !(cmdPhase && cmdOk && (e.kind == 3'b000));
        obsCmd = {bif.mrdc_n, bif.mwtc_n, bif.amwc_n, bif.iorc_n,
                  bif.iowc_n, bif.aiowc_n, bif.inta_n};
        readLows = int'(!bif.mrdc_n) + int'(!bif.iorc_n) + int'(!bif.inta_n);
        checkOutput("busState", 16'(bif.bus_state), 16'(e.ph), period);
        checkOutput("ale", 16'(bif.ale), 16'(expAle), period);
        checkOutput("den", 16'(bif.den), 16'(expDen), period);
        checkOutput("dtR", 16'(bif.dt_r_n), 16'(expDtr), period);
        checkOutput("commands", 16'(obsCmd), 16'(expCmd), period);
        checkOutput("oneReadCmd", 16'(readLows <= 1), 16'd1, period);
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;

        // Clock 0 holds reset; nothing is checked before the first edge.
        pushPhase(PH_NONE, 3'b111, GATE_ON, 1'b1);
        addIdle(2);
        addCycle(3'b101, 0, GATE_ON, -1);
        addIdle(1);
        addCycle(3'b010, 2, GATE_ON, -1);
        addIdle(1);
        addCycle(3'b101, 0, GATE_ON, -1);
        addCycle(3'b110, 1, GATE_ON, -1);
        addIdle(1);
        addHalt(3);
        addIdle(1);
        addCycle(3'b000, 0, GATE_AEN, -1);
        addCycle(3'b101, 1, GATE_CEN, -1);
        addIdle(1);
        addCycle(3'b110, 1, GATE_ON, 2);
        addCycle(3'b001, 0, GATE_ON, -1);
        addCycle(3'b100, 1, GATE_ON, -1);
        addHalt(2);

        for (int k = 0; k < 160; k++) begin
            case ($urandom_range(0, 9))
                6:       addHalt($urandom_range(1, 3));
                7:       addIdle($urandom_range(1, 2));
                8:       addCycle(randKind(), $urandom_range(0, 3), GATE_RAND, $urandom_range(0, 2));
                default: addCycle(randKind(), $urandom_range(0, 3), GATE_RAND, -1);
            endcase
        end
        addIdle(2);
        fillStatus();

        applyStimulus(plan[0]);
        for (int i = 1; i < plan.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(plan[i]);
            @(negedge clk);
            checkEntry(plan[i], i);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
